// File: rtl/acc_cpu_pkg.sv
// Shared encodings for the parametrised accumulator CPU: host commands and opcodes.
package acc_cpu_pkg;

  typedef enum logic [1:0] {
    CMD_REWIND    = 2'd0,
    CMD_LOAD_CODE = 2'd1,
    CMD_LOAD_DATA = 2'd2,
    CMD_RUN       = 2'd3
  } cmd_e;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_BZ    = 3'd4;
  localparam logic [2:0] OP_BC    = 3'd5;
  localparam logic [2:0] OP_OUT   = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational add/subtract for the accumulator; o_c is carry on add, borrow on subtract.
module acc_cpu_alu #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic          i_sub,
  output logic [DW-1:0] o_y,
  output logic          o_c
);

  logic [DW:0] w_sum;

  // Zero-extended subtraction: the top bit is set exactly when i_a < i_b.
  always_comb begin
    w_sum = '0;
    if (i_sub) w_sum = {1'b0, i_a} - {1'b0, i_b};
    else       w_sum = {1'b0, i_a} + {1'b0, i_b};
  end

  assign o_y = w_sum[DW-1:0];
  assign o_c = w_sum[DW];

endmodule

// File: rtl/acc_cpu_param.sv
// Accumulator CPU core: host loads code/data through cmd, Run executes one instruction per clock.
module acc_cpu_param
  import acc_cpu_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cmd,
  input  logic [DW-1:0] cmd_arg,
  input  logic [AW-1:0] start_pc,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc,
  output logic          carry,
  output logic          halted,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  localparam int DEPTH = 2 ** AW;

  logic [2:0]    r_code [DEPTH];
  logic [DW-1:0] r_data [DEPTH];

  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_acc;
  logic          r_carry;
  logic          r_halted;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;

  logic [2:0]    w_op;
  logic [DW-1:0] w_arg;
  logic [AW-1:0] w_tgt;
  logic [AW-1:0] w_pc_inc;
  logic [DW-1:0] w_alu_y;
  logic          w_alu_c;

  assign w_op     = r_code[r_pc];
  assign w_arg    = r_data[r_pc];
  assign w_tgt    = w_arg[AW-1:0];
  assign w_pc_inc = r_pc + AW'(1);

  acc_cpu_alu #(.DW(DW)) u_alu (
    .i_a   (r_acc),
    .i_b   (w_arg),
    .i_sub (w_op == OP_SUB),
    .o_y   (w_alu_y),
    .o_c   (w_alu_c)
  );

  // Memories are never reset so a program survives reset and Rewind.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      case (cmd)
        CMD_LOAD_CODE: r_code[r_pc] <= cmd_arg[2:0];
        CMD_LOAD_DATA: r_data[r_pc] <= cmd_arg;
        CMD_RUN: if (!r_halted && w_op == OP_STORE) r_data[w_tgt] <= r_acc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= start_pc;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_halted    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (cmd)
        CMD_REWIND: begin
          r_pc       <= start_pc;
          r_acc      <= '0;
          r_carry    <= 1'b0;
          r_halted   <= 1'b0;
          r_out_data <= '0;
        end
        CMD_LOAD_CODE, CMD_LOAD_DATA: begin
          r_pc     <= w_pc_inc;
          r_halted <= 1'b0;
        end
        CMD_RUN: begin
          if (!r_halted) begin
            r_pc <= w_pc_inc;
            case (w_op)
              OP_LOAD: r_acc <= w_arg;
              OP_ADD, OP_SUB: begin
                r_acc   <= w_alu_y;
                r_carry <= w_alu_c;
              end
              OP_BZ: if (r_acc == '0) r_pc <= w_tgt;
              OP_BC: if (r_carry) r_pc <= w_tgt;
              OP_OUT: begin
                r_out_data  <= r_acc;
                r_out_valid <= 1'b1;
              end
              OP_HALT: begin
                r_halted <= 1'b1;
                r_pc     <= r_pc;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign pc        = r_pc;
  assign acc       = r_acc;
  assign carry     = r_carry;
  assign halted    = r_halted;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_acc_cpu_param.sv
// Bench for acc_cpu_param (DW=4, AW=3): arithmetic reference model, per-cycle state scoreboard, OUT event queue.
module tb_acc_cpu_param;

  localparam int W = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic [2:0] start_pc = 3'd0;
  logic [2:0] pc;
  logic [3:0] acc;
  logic       carry;
  logic       halted;
  logic       out_valid;
  logic [3:0] out_data;

  acc_cpu_param #(.DW(4), .AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd),
    .cmd_arg   (cmd_arg),
    .start_pc  (start_pc),
    .pc        (pc),
    .acc       (acc),
    .carry     (carry),
    .halted    (halted),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Reference machine state, plain integers
  int m_code [8];
  int m_data [8];
  int m_pc, m_acc, m_carry, m_halted, m_ov, m_od;

  logic [W-1:0] exp_q [$];
  logic [3:0]   out_q [$];
  int n_checks = 0;
  int n_fail = 0;
  logic started = 1'b0;
  int prog_code [8];
  int prog_data [8];

  function automatic logic [W-1:0] pack_st(int p, int a, int c, int h, int ov, int od);
    return {3'(p), 4'(a), 1'(c), 1'(h), 1'(ov), 4'(od)};
  endfunction

  task automatic model_step(input logic r, input int c, input int a, input int sp);
    m_ov = 0;
    if (!r || c == 0) begin
      m_pc = sp; m_acc = 0; m_carry = 0; m_halted = 0; m_od = 0;
    end else if (c == 1) begin
      m_code[m_pc] = a % 8; m_pc = (m_pc + 1) % 8; m_halted = 0;
    end else if (c == 2) begin
      m_data[m_pc] = a; m_pc = (m_pc + 1) % 8; m_halted = 0;
    end else if (m_halted == 0) begin
      int op, arg, nxt;
      op  = m_code[m_pc];
      arg = m_data[m_pc];
      nxt = (m_pc + 1) % 8;
      case (op)
        0: m_acc = arg;
        1: m_data[arg % 8] = m_acc;
        2: begin m_carry = (m_acc + arg > 15) ? 1 : 0; m_acc = (m_acc + arg) % 16; end
        3: begin m_carry = (m_acc < arg) ? 1 : 0; m_acc = (m_acc - arg + 16) % 16; end
        4: if (m_acc == 0) nxt = arg % 8;
        5: if (m_carry != 0) nxt = arg % 8;
        6: begin m_od = m_acc; m_ov = 1; end
        default: begin m_halted = 1; nxt = m_pc; end
      endcase
      m_pc = nxt;
    end
  endtask

  // One clock of stimulus: apply inputs, advance the model, queue the expected post-edge state
  task automatic drive(input logic r, input int c, input int a, input int sp);
    @(negedge clk);
    rst_n = r; cmd = 2'(c); cmd_arg = 4'(a); start_pc = 3'(sp);
    model_step(r, c, a, sp);
    exp_q.push_back(pack_st(m_pc, m_acc, m_carry, m_halted, m_ov, m_od));
    if (m_ov != 0) out_q.push_back(4'(m_od));
    started = 1'b1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 3, $urandom_range(0, 15), $urandom_range(0, 7));
  endtask

  task automatic load_prog();
    drive(1'b1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1, prog_code[i], 0);
    for (int i = 0; i < 8; i++) drive(1'b1, 2, prog_data[i], 0);
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  // Monitor: state compare every issued cycle, OUT strobes matched against queued values
  logic [W-1:0] mon_exp, mon_got;
  logic [3:0]   mon_od;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_got = {pc, acc, carry, halted, out_valid, out_data};
        n_checks++;
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL state: got pc=%0d acc=%0d c=%0d h=%0d ov=%0d od=%0d required pc=%0d acc=%0d c=%0d h=%0d ov=%0d od=%0d",
                   mon_got[13:11], mon_got[10:7], mon_got[6], mon_got[5], mon_got[4], mon_got[3:0],
                   mon_exp[13:11], mon_exp[10:7], mon_exp[6], mon_exp[5], mon_exp[4], mon_exp[3:0]);
        end
      end
      if (started && out_valid === 1'b1) begin
        n_checks++;
        if (out_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_event: got unexpected strobe out_data=%0d required no strobe", out_data);
        end else begin
          mon_od = out_q.pop_front();
          if (out_data !== mon_od) begin
            n_fail++;
            $display("FAIL out_event: got out_data=%0d required %0d", out_data, mon_od);
          end
        end
      end
    end
  end

  initial begin
    // Reset with start_pc=5
    drive(1'b0, 0, 0, 5);
    sample();
    check("reset_pc", int'(pc), 5);
    check("reset_acc", int'(acc), 0);
    check("reset_flags", int'({carry, halted, out_valid}), 0);

    // 8 LoadCode with bit3 set: LOAD,ADD,BC,-,-,OUT,HALT,-
    prog_code = '{0, 2, 5, 0, 0, 6, 7, 7};
    drive(1'b1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1, prog_code[i] | 8, 0);
    sample();
    check("loadcode_wrap_pc", int'(pc), 0);
    prog_data = '{9, 9, 5, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) drive(1'b1, 2, prog_data[i], 0);

    // Program trace: LOAD 9, ADD 9, BC->5, OUT, HALT
    drive(1'b1, 3, 0, 0); sample();
    check("t3_load_acc", int'(acc), 9);
    drive(1'b1, 3, 0, 0); sample();
    check("t3_add_acc", int'(acc), 2);
    check("t3_add_carry", int'(carry), 1);
    drive(1'b1, 3, 0, 0); sample();
    check("t3_bc_pc", int'(pc), 5);
    drive(1'b1, 3, 0, 0); sample();
    check("t3_out_valid", int'(out_valid), 1);
    check("t3_out_data", int'(out_data), 2);
    drive(1'b1, 3, 0, 0); sample();
    check("t3_strobe_len", int'(out_valid), 0);
    check("t3_halted", int'(halted), 1);
    run_n(3); sample();
    check("t3_halt_pc", int'(pc), 6);

    // Rewind and replay the same trace, then reset mid-run and replay again
    drive(1'b1, 0, 0, 0);
    run_n(7);
    drive(1'b1, 0, 0, 0);
    run_n(2);
    drive(1'b0, 3, 0, 3); sample();
    check("midrun_reset_pc", int'(pc), 3);
    drive(1'b1, 0, 0, 0);
    run_n(7); sample();
    check("replay_out_data", int'(out_data), 2);

    // SUB with borrow, then SUB 0 clears carry
    prog_code = '{0, 3, 3, 7, 7, 7, 7, 7};
    prog_data = '{3, 5, 0, 0, 0, 0, 0, 0};
    load_prog();
    drive(1'b1, 3, 0, 0);
    drive(1'b1, 3, 0, 0); sample();
    check("sub_borrow_acc", int'(acc), 14);
    check("sub_borrow_carry", int'(carry), 1);
    drive(1'b1, 3, 0, 0); sample();
    check("sub0_acc", int'(acc), 14);
    check("sub0_carry", int'(carry), 0);

    // STORE 7 to data[4], BZ to 4, LOAD picks up the stored value
    prog_code = '{0, 1, 0, 4, 0, 7, 7, 7};
    prog_data = '{7, 4, 0, 4, 0, 0, 0, 0};
    load_prog();
    run_n(5); sample();
    check("store_reload_acc", int'(acc), 7);
    check("store_reload_pc", int'(pc), 5);

    // Randomised programs and command mixes
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 8; i++) begin
        prog_code[i] = $urandom_range(0, 15);
        prog_data[i] = $urandom_range(0, 15);
      end
      load_prog();
      drive(1'b1, 0, 0, $urandom_range(0, 7));
      for (int k = 0; k < 40; k++) begin
        int x;
        x = $urandom_range(0, 99);
        if (x < 2)       drive(1'b0, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7));
        else if (x < 5)  drive(1'b1, 0, $urandom_range(0, 15), $urandom_range(0, 7));
        else if (x < 9)  drive(1'b1, 1, $urandom_range(0, 15), $urandom_range(0, 7));
        else if (x < 13) drive(1'b1, 2, $urandom_range(0, 15), $urandom_range(0, 7));
        else             drive(1'b1, 3, $urandom_range(0, 15), $urandom_range(0, 7));
      end
    end

    @(posedge clk);
    #3;
    check("state_queue_drained", exp_q.size(), 0);
    check("out_queue_drained", out_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
